// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, FSM states,
// access sizes and byte-mask constants.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BM_NONE = 4'b0000;
    localparam logic [3:0] BM_B    = 4'b0001;
    localparam logic [3:0] BM_H_LO = 4'b0011;
    localparam logic [3:0] BM_H_HI = 4'b1100;
    localparam logic [3:0] BM_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Undefined funct3 encodings fall through to word accesses.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3_size(f3))
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lo[0];
            default: misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Handshake: mem_req stays high until the slave answers with a one-cycle mem_ack.
interface lsu_if #(parameter int ADDR_W = 32) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_bmask;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_bmask,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_bmask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_ld_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to funct3.
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = i_rdata >> {i_addr_lo, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_result = {{24{byte_v[7]}}, byte_v};
            F3_BU:   o_result = {24'h0, byte_v};
            F3_H:    o_result = {{16{half_v[15]}}, half_v};
            F3_HU:   o_result = {16'h0, half_v};
            default: o_result = i_rdata;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: launches one memory request per instruction, stalls the core
// until the ack (or timeout), aligns load data and builds store byte masks.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_lsu_en,
    input  logic              i_lsu_wren,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [31:0]       i_st_data,
    output logic [31:0]       o_ld_data,
    output logic              o_stall,
    output logic              o_misalign,
    output logic              o_bus_err,
    output lsu_state_e        o_state,
    lsu_if.master             mem
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              bus_err_q, bus_err_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lo_q, lo_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        bmask_q, bmask_d;
    logic [31:0]       align_data;
    logic              mis;

    lsu_ld_align u_align (
        .i_rdata   (mem.mem_rdata),
        .i_addr_lo (lo_q),
        .i_funct3  (funct3_q),
        .o_result  (align_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            bus_err_q <= 1'b0;
            ld_data_q <= '0;
            addr_q    <= '0;
            lo_q      <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            bmask_q   <= BM_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            bus_err_q <= bus_err_d;
            ld_data_q <= ld_data_d;
            addr_q    <= addr_d;
            lo_q      <= lo_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            bmask_q   <= bmask_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        ld_data_d = ld_data_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        bmask_d   = bmask_q;
        mis       = i_lsu_en && misaligned(i_funct3, i_lsu_addr[1:0]);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_lsu_en && !mis) begin
                    addr_d   = {i_lsu_addr[ADDR_W-1:2], 2'b00};
                    lo_d     = i_lsu_addr[1:0];
                    funct3_d = i_funct3;
                    we_d     = i_lsu_wren;
                    wdata_d  = '0;
                    bmask_d  = BM_NONE;
                    if (i_lsu_wren) begin
                        case (f3_size(i_funct3))
                            SZ_B: begin
                                wdata_d = {4{i_st_data[7:0]}};
                                bmask_d = BM_B << i_lsu_addr[1:0];
                            end
                            SZ_H: begin
                                wdata_d = {2{i_st_data[15:0]}};
                                bmask_d = i_lsu_addr[1] ? BM_H_HI : BM_H_LO;
                            end
                            default: begin
                                wdata_d = i_st_data;
                                bmask_d = BM_W;
                            end
                        endcase
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    if (!we_q) ld_data_d = align_data;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: the error pulse lands in the DONE cycle.
                    ld_data_d = '0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_d = (state_d == REQ);
    end

    assign o_ld_data     = ld_data_q;
    assign o_bus_err     = bus_err_q;
    assign o_misalign    = mis;
    assign o_stall       = i_lsu_en && (state_q != DONE) && !mis;
    assign o_state       = state_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_bmask = bmask_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of single accesses plus
// hand-written reset-abort and stray-ack sequences.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        lsu_en;
    logic        lsu_wren;
    logic [2:0]  funct3;
    logic [31:0] lsu_addr;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    lsu_state_e  state;

    int tests_run = 0;
    int tests_failed = 0;

    lsu_if #(.ADDR_W(32)) mem_bus ();

    lsu_ctrl #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_lsu_en   (lsu_en),
        .i_lsu_wren (lsu_wren),
        .i_funct3   (funct3),
        .i_lsu_addr (lsu_addr),
        .i_st_data  (st_data),
        .o_ld_data  (ld_data),
        .o_stall    (stall),
        .o_misalign (misalign),
        .o_bus_err  (bus_err),
        .o_state    (state),
        .mem        (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] rdata;
        int          ack_wait;
        logic        exp_mis;
        int          exp_stall;
        int          exp_req;
        int          exp_berr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_bmask;
        logic [31:0] exp_ld;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Runs one access; ack_wait = REQ cycles without ack before the ack cycle.
    task automatic run_vec(input vec_t v);
        int          stall_n, req_n, berr_n;
        logic        got_mis, finished;
        logic [31:0] got_addr, got_wdata;
        logic [3:0]  got_bmask;
        logic        got_we;
        stall_n = 0; req_n = 0; berr_n = 0; finished = 1'b0;
        got_addr = '0; got_wdata = '0; got_bmask = '0; got_we = 1'b0;
        @(negedge clk);
        lsu_en = 1'b1; lsu_wren = v.wren; funct3 = v.f3;
        lsu_addr = v.addr; st_data = v.st;
        #1;
        got_mis = misalign;
        for (int c = 0; c < 64 && !finished; c++) begin
            if (mem_bus.mem_req) begin
                req_n++;
                got_addr = mem_bus.mem_addr; got_wdata = mem_bus.mem_wdata;
                got_bmask = mem_bus.mem_bmask; got_we = mem_bus.mem_we;
                mem_bus.mem_ack = ((req_n - 1) == v.ack_wait);
                mem_bus.mem_rdata = mem_bus.mem_ack ? v.rdata : 32'hDEAD_BEEF;
            end else begin
                mem_bus.mem_ack = 1'b0;
            end
            if (bus_err) berr_n++;
            if (stall) stall_n++;
            else finished = 1'b1;
            if (!finished) begin
                @(negedge clk);
                #1;
            end
        end
        chk({v.name, " done"}, 32'(finished), 32'd1);
        chk({v.name, " misalign"}, 32'(got_mis), 32'(v.exp_mis));
        chk({v.name, " stall_cycles"}, 32'(stall_n), 32'(v.exp_stall));
        chk({v.name, " req_cycles"}, 32'(req_n), 32'(v.exp_req));
        chk({v.name, " bus_err"}, 32'(berr_n), 32'(v.exp_berr));
        chk({v.name, " ld_data"}, ld_data, v.exp_ld);
        if (v.exp_req > 0) begin
            chk({v.name, " mem_addr"}, got_addr, v.exp_addr);
            chk({v.name, " mem_we"}, 32'(got_we), 32'(v.wren));
            chk({v.name, " mem_wdata"}, got_wdata, v.exp_wdata);
            chk({v.name, " mem_bmask"}, 32'(got_bmask), 32'(v.exp_bmask));
        end
        // Core retires; the still-high enable during DONE must not relaunch.
        @(negedge clk);
        lsu_en = 1'b0; mem_bus.mem_ack = 1'b0;
        #1;
        chk({v.name, " back_idle"}, 32'(state), 32'(IDLE));
        chk({v.name, " no_relaunch"}, 32'(mem_bus.mem_req), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"lb_103",   F3_B,   1'b0, 32'h103, 32'h0,         32'h80FF_1234, 0,   1'b0, 2,  1,  0, 32'h100, 32'h0,         4'b0000, 32'hFFFF_FF80};
        vecs[1]  = '{"lhu_102",  F3_HU,  1'b0, 32'h102, 32'h0,         32'hBEEF_0000, 3,   1'b0, 5,  4,  0, 32'h100, 32'h0,         4'b0000, 32'h0000_BEEF};
        vecs[2]  = '{"sb_201",   F3_B,   1'b1, 32'h201, 32'h0000_00AB, 32'h0,         1,   1'b0, 3,  2,  0, 32'h200, 32'hABAB_ABAB, 4'b0010, 32'h0000_BEEF};
        vecs[3]  = '{"lw_mis",   F3_W,   1'b0, 32'h302, 32'h0,         32'h0,         0,   1'b1, 0,  0,  0, 32'h0,   32'h0,         4'b0000, 32'h0000_BEEF};
        vecs[4]  = '{"lh_206",   F3_H,   1'b0, 32'h206, 32'h0,         32'h8001_7FFF, 0,   1'b0, 2,  1,  0, 32'h204, 32'h0,         4'b0000, 32'hFFFF_8001};
        vecs[5]  = '{"lbu_105",  F3_BU,  1'b0, 32'h105, 32'h0,         32'h1234_F6AA, 0,   1'b0, 2,  1,  0, 32'h104, 32'h0,         4'b0000, 32'h0000_00F6};
        vecs[6]  = '{"sh_10a",   F3_H,   1'b1, 32'h10A, 32'h1234_CAFE, 32'h0,         0,   1'b0, 2,  1,  0, 32'h108, 32'hCAFE_CAFE, 4'b1100, 32'h0000_00F6};
        vecs[7]  = '{"sw_40c",   F3_W,   1'b1, 32'h40C, 32'hDEAD_BEEF, 32'h0,         2,   1'b0, 4,  3,  0, 32'h40C, 32'hDEAD_BEEF, 4'b1111, 32'h0000_00F6};
        vecs[8]  = '{"lh_mis",   F3_H,   1'b0, 32'h101, 32'h0,         32'h0,         0,   1'b1, 0,  0,  0, 32'h0,   32'h0,         4'b0000, 32'h0000_00F6};
        vecs[9]  = '{"sb_003",   F3_B,   1'b1, 32'h003, 32'h0000_005A, 32'h0,         0,   1'b0, 2,  1,  0, 32'h000, 32'h5A5A_5A5A, 4'b1000, 32'h0000_00F6};
        vecs[10] = '{"lw_020",   F3_W,   1'b0, 32'h020, 32'h0,         32'h7654_3210, 0,   1'b0, 2,  1,  0, 32'h020, 32'h0,         4'b0000, 32'h7654_3210};
        vecs[11] = '{"f3_011m",  3'b011, 1'b0, 32'h022, 32'h0,         32'h0,         0,   1'b1, 0,  0,  0, 32'h0,   32'h0,         4'b0000, 32'h7654_3210};
        vecs[12] = '{"f3_111",   3'b111, 1'b0, 32'h044, 32'h0,         32'h8888_0001, 0,   1'b0, 2,  1,  0, 32'h044, 32'h0,         4'b0000, 32'h8888_0001};
        vecs[13] = '{"lw_tmo",   F3_W,   1'b0, 32'h050, 32'h0,         32'h1111_1111, 255, 1'b0, 17, 16, 1, 32'h050, 32'h0,         4'b0000, 32'h0000_0000};
        vecs[14] = '{"lb_060",   F3_B,   1'b0, 32'h060, 32'h0,         32'h0000_007F, 0,   1'b0, 2,  1,  0, 32'h060, 32'h0,         4'b0000, 32'h0000_007F};

        rst = 1'b1; lsu_en = 1'b0; lsu_wren = 1'b0; funct3 = '0;
        lsu_addr = '0; st_data = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst state", 32'(state), 32'(IDLE));
        chk("rst ld_data", ld_data, 32'h0);
        chk("rst mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Stray ack while idle must not disturb the load register.
        @(negedge clk);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        #1;
        chk("stray_ack ld_data", ld_data, 32'h0000_007F);
        chk("stray_ack state", 32'(state), 32'(IDLE));

        // Reset in the middle of REQ aborts the access.
        @(negedge clk);
        lsu_en = 1'b1; lsu_wren = 1'b0; funct3 = F3_W; lsu_addr = 32'h070;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_rst pre req", 32'(mem_bus.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1; lsu_en = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("mid_rst state", 32'(state), 32'(IDLE));
        chk("mid_rst ld_data", ld_data, 32'h0);
        chk("mid_rst bmask", 32'(mem_bus.mem_bmask), 32'd0);
        chk("mid_rst stall", 32'(stall), 32'd0);
        rst = 1'b0;
        run_vec('{"lw_after_rst", F3_W, 1'b0, 32'h074, 32'h0, 32'hA5A5_5A5A, 1, 1'b0, 3, 2, 0,
                  32'h074, 32'h0, 4'b0000, 32'hA5A5_5A5A});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
